otp_auth_engine: RTL and testbench
==================================

# otp_auth_engine

Parametrised one-time-password authentication engine: generates an OTP of DIGITS BCD digits from an internal LFSR, collects a user-entered code one digit per latch press, and grants or denies access. It adds three things to the first-generation OTP path: a configurable digit count, a configurable attempt limit, and a timed lockout, so a permanent system reset is no longer needed after too many failures. It sits between the push-button/switch inputs and the seven-segment display driver, which consumes `otp_digits`, `user_digits` and the status flags.

## Interface
Parameters:
- DIGITS, 4: OTP length in BCD digits (1–8).
- LFSR_W, 16: PRNG width. Legal values are 16, 24 and 32. Must satisfy LFSR_W ≥ 4·DIGITS.
- SEED, 16'hACE1: LFSR reset value. Must be non-zero and is zero-extended to LFSR_W.
- MAX_ATTEMPTS, 3: number of wrong codes that triggers lockout (≥1).
- EXPIRE_CYCLES, 1000: entry window, counted from OTP issue.
- LOCK_CYCLES, 200: lockout duration.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- user_digit  in  4  BCD digit from switches.
- otp_latch  in  1  level input; its rising edge requests a new OTP.
- user_latch  in  1  level input; its rising edge enters `user_digit`.
- otp_digits  out  4·DIGITS  issued OTP in BCD, most significant digit in the top nibble.
- user_digits  out  4·DIGITS  digits entered so far; the newest digit is in the low nibble.
- unlock  out  1  access granted.
- locked  out  1  lockout in progress.
- expired  out  1  entry window elapsed.
- wrng_atmpt  out  $clog2(MAX_ATTEMPTS+1)  number of wrong attempts.

## Operation
- Both latch inputs pass through internal rising-edge detectors. A rise pulse is asserted for exactly 1 cycle, one cycle after the input is first sampled high.
- The LFSR free-runs every cycle in all states. It holds SEED while reset is asserted.
- OTP digit rule: each nibble k of the LFSR's low 4·DIGITS bits is reduced to a digit as follows. If the nibble is ≥ 10, the digit is nibble − 10; otherwise the digit is the nibble.
- A `user_digit` value > 9 is ignored: the press is not counted and no flag changes.
- FSM states:
  - IDLE → ISSUE on an otp rise.
  - ISSUE: capture `otp_digits`, clear `user_digits`, clear the digit count, start the expiry timer, then go to ENTRY.
  - ENTRY: on each valid user rise, shift the digit into `user_digits` and increment the count. When the count reaches DIGITS, go to CHECK. When the timer reaches EXPIRE_CYCLES, set `expired` and go to IDLE.
  - CHECK (1 cycle): on a match, set `unlock`, clear `wrng_atmpt`, go to UNLOCKED. On a mismatch, increment `wrng_atmpt`. If the new count equals MAX_ATTEMPTS, go to LOCKOUT; otherwise go to IDLE.
  - UNLOCKED: `unlock` stays high. An otp rise clears it and goes to ISSUE.
  - LOCKOUT: `locked` is high and all latch inputs are ignored. After LOCK_CYCLES cycles: clear `locked`, clear `wrng_atmpt`, go to IDLE.
- `expired` is held until the next otp rise.
- An otp rise in ENTRY restarts the session: go to ISSUE with a new OTP. `wrng_atmpt` is unchanged.
- If otp and user rises arrive in the same cycle, the otp rise wins and the user press is dropped.
- If the timer expires in the same cycle as the final digit press, expiry wins.
- Reset asserted mid-operation returns the FSM to IDLE immediately.

## Timing
- Reset values: state IDLE, `otp_digits`=0, `user_digits`=0, `unlock`=0, `locked`=0, `expired`=0, `wrng_atmpt`=0, LFSR=SEED.
- An otp rise pulse in cycle N produces ISSUE in N+1 and `otp_digits` valid in N+2.
- A user rise pulse in cycle N updates `user_digits` in N+1.
- For the final digit: CHECK in N+1, with `unlock`, `wrng_atmpt` or `locked` updated in N+2.
- The expiry timer counts ENTRY cycles starting at ISSUE+1. `expired` rises exactly EXPIRE_CYCLES cycles after ENTRY is entered.
- `locked` is high for exactly LOCK_CYCLES cycles.

## Configuration
- OTP_AUTH_TIMEOUT_EN defined: the expiry timer and the ENTRY→IDLE timeout path are present.
- OTP_AUTH_TIMEOUT_EN undefined: there is no timer, `expired` is tied 0, and ENTRY waits indefinitely. The EXPIRE_CYCLES parameter is accepted but unused.

## Structure
- Package otp_auth_pkg contains:
  - the FSM state enum;
  - the LFSR tap constants for widths 16, 24 and 32;
  - the function that reduces a nibble to a BCD digit.
- Sub-module otp_prng: parametrised Galois LFSR with a width and seed parameter, taking taps from the package.
- The edge detectors, FSM, timers and comparator are in otp_auth_engine.

## Test plan
- Defaults: release reset, pulse otp_latch with the LFSR low bits at 16'hACE1 → `otp_digits`=16'h0241. Enter 0,2,4,1 → `unlock`=1 two cycles after the 4th rise pulse, `wrng_atmpt`=0.
- Three sessions, each entering 9,9,9,9 → `wrng_atmpt` goes 1, 2, then `locked`=1. Latch presses during lockout have no effect. After 200 cycles `locked`=0 and `wrng_atmpt`=0.
- Issue an OTP, enter 2 digits, then idle → `expired`=1 exactly 1000 cycles after ENTRY begins; the next otp rise clears it.
- Enter `user_digit`=4'hC → ignored, digit count unchanged. Otp and user rises in the same cycle → new OTP issued, `user_digits`=0.
- Assert reset in ENTRY after 3 digits → all outputs return to their reset values asynchronously, and the next OTP sequence restarts from SEED.
- Build with OTP_AUTH_TIMEOUT_EN undefined → 5000 idle cycles in ENTRY leave `expired`=0, and a correct code still unlocks.

Source files
------------

// File: rtl/otp_auth_pkg.sv
// Shared definitions for the OTP authentication engine: FSM state codes,
// Galois LFSR tap masks and the nibble-to-BCD digit reduction.
package otp_auth_pkg;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ISSUE    = 3'd1;
    localparam state_t ST_ENTRY    = 3'd2;
    localparam state_t ST_CHECK    = 3'd3;
    localparam state_t ST_UNLOCKED = 3'd4;
    localparam state_t ST_LOCKOUT  = 3'd5;

    // Right-shifting Galois masks for maximal-length polynomials
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [23:0] LFSR_TAPS_24 = 24'hE1_0000;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            24:      taps = 32'(LFSR_TAPS_24);
            32:      taps = LFSR_TAPS_32;
            default: taps = 32'(LFSR_TAPS_16);
        endcase
        return taps;
    endfunction

    // Folds 10..15 onto 0..5 so every nibble yields a decimal digit
    function automatic logic [3:0] nibble_to_bcd(input logic [3:0] nibble);
        return (nibble >= 4'd10) ? nibble - 4'd10 : nibble;
    endfunction

endpackage

// File: rtl/otp_auth_engine_if.sv
// Switch/button inputs and display-facing outputs of the OTP engine.
interface otp_auth_engine_if #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned MAX_ATTEMPTS = 3
);
    localparam int unsigned CODE_W = 4 * DIGITS;
    localparam int unsigned ATT_W  = $clog2(MAX_ATTEMPTS + 1);

    logic [3:0]        user_digit;
    logic              otp_latch;
    logic              user_latch;
    logic [CODE_W-1:0] otp_digits;
    logic [CODE_W-1:0] user_digits;
    logic              unlock;
    logic              locked;
    logic              expired;
    logic [ATT_W-1:0]  wrng_atmpt;

    modport master (
        output user_digit, otp_latch, user_latch,
        input  otp_digits, user_digits, unlock, locked, expired, wrng_atmpt
    );

    modport slave (
        input  user_digit, otp_latch, user_latch,
        output otp_digits, user_digits, unlock, locked, expired, wrng_atmpt
    );

endinterface

// File: rtl/otp_prng.sv
// Free-running Galois LFSR; holds SEED (zero-extended) while reset is high.
module otp_prng
    import otp_auth_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter logic [31:0] SEED  = 32'h0000_ACE1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WIDTH'(SEED);
        end else if (state[0]) begin
            state <= (state >> 1) ^ TAPS;
        end else begin
            state <= state >> 1;
        end
    end

endmodule

// File: rtl/otp_auth_engine.sv
// OTP authentication engine: issue code from LFSR, collect digits, compare,
// count failures and lock out. Define OTP_AUTH_TIMEOUT_EN for the entry timer.
module otp_auth_engine
    import otp_auth_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned LFSR_W        = 16,
    parameter logic [31:0] SEED          = 32'h0000_ACE1,
    parameter int unsigned MAX_ATTEMPTS  = 3,
    parameter int unsigned EXPIRE_CYCLES = 1000,
    parameter int unsigned LOCK_CYCLES   = 200
) (
    input logic              clk,
    input logic              reset,
    otp_auth_engine_if.slave bus
);

    localparam int unsigned CODE_W = 4 * DIGITS;
    localparam int unsigned ATT_W  = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

    logic              otp_q, otp_qq, usr_q, usr_qq;
    logic [3:0]        digit_q;
    logic              otp_rise_c, user_rise_c, digit_ok_c, timeout_c;
    logic [LFSR_W-1:0] lfsr;
    logic [CODE_W-1:0] otp_next_c;

    state_t            state, state_nxt;
    logic [CODE_W-1:0] otp_r, otp_nxt, usr_r, usr_nxt;
    logic              unlock_r, unlock_nxt, locked_r, locked_nxt;
    logic [ATT_W-1:0]  wrng_r, wrng_nxt;
    logic [CNT_W-1:0]  dcnt, dcnt_nxt;
    logic [LOCK_W-1:0] lcnt, lcnt_nxt;

    otp_prng #(.WIDTH(LFSR_W), .SEED(SEED)) u_prng (
        .clk   (clk),
        .reset (reset),
        .state (lfsr)
    );

    // Input sampling; the digit is delayed with the latch so it aligns with the rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            otp_q   <= 1'b0;
            otp_qq  <= 1'b0;
            usr_q   <= 1'b0;
            usr_qq  <= 1'b0;
            digit_q <= 4'd0;
        end else begin
            otp_q   <= bus.otp_latch;
            otp_qq  <= otp_q;
            usr_q   <= bus.user_latch;
            usr_qq  <= usr_q;
            digit_q <= bus.user_digit;
        end
    end

    assign otp_rise_c  = otp_q & ~otp_qq;
    assign user_rise_c = usr_q & ~usr_qq;
    assign digit_ok_c  = (digit_q <= 4'd9);

    always_comb begin
        otp_next_c = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            otp_next_c[4*k +: 4] = nibble_to_bcd(lfsr[4*k +: 4]);
        end
    end

`ifdef OTP_AUTH_TIMEOUT_EN
    localparam int unsigned EXP_W = $clog2(EXPIRE_CYCLES + 1);

    logic [EXP_W-1:0] tmr, tmr_nxt;
    logic             expired_r, expired_nxt;

    assign timeout_c = (state == ST_ENTRY) && (tmr == EXP_W'(EXPIRE_CYCLES - 1));

    // Entry-window timer counts ENTRY cycles; expired holds until an accepted otp rise
    always_comb begin
        tmr_nxt     = tmr;
        expired_nxt = expired_r;
        if (state == ST_ISSUE) begin
            tmr_nxt = '0;
        end else if (state == ST_ENTRY) begin
            tmr_nxt = tmr + EXP_W'(1);
        end
        if (otp_rise_c && (state != ST_LOCKOUT)) begin
            expired_nxt = 1'b0;
        end else if (timeout_c) begin
            expired_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr       <= '0;
            expired_r <= 1'b0;
        end else begin
            tmr       <= tmr_nxt;
            expired_r <= expired_nxt;
        end
    end

    assign bus.expired = expired_r;
`else
    // No timer to size in this build; EXPIRE_CYCLES is accepted and ignored
    logic unused_expire;
    assign unused_expire = ^EXPIRE_CYCLES;
    assign timeout_c     = 1'b0;
    assign bus.expired   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            otp_r    <= '0;
            usr_r    <= '0;
            unlock_r <= 1'b0;
            locked_r <= 1'b0;
            wrng_r   <= '0;
            dcnt     <= '0;
            lcnt     <= '0;
        end else begin
            state    <= state_nxt;
            otp_r    <= otp_nxt;
            usr_r    <= usr_nxt;
            unlock_r <= unlock_nxt;
            locked_r <= locked_nxt;
            wrng_r   <= wrng_nxt;
            dcnt     <= dcnt_nxt;
            lcnt     <= lcnt_nxt;
        end
    end

    // Next state and register updates; otp rise outranks timeout, timeout outranks a digit
    always_comb begin
        state_nxt  = state;
        otp_nxt    = otp_r;
        usr_nxt    = usr_r;
        unlock_nxt = unlock_r;
        locked_nxt = locked_r;
        wrng_nxt   = wrng_r;
        dcnt_nxt   = dcnt;
        lcnt_nxt   = lcnt;
        case (state)
            ST_IDLE: begin
                if (otp_rise_c) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                otp_nxt   = otp_next_c;
                usr_nxt   = '0;
                dcnt_nxt  = '0;
                state_nxt = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (otp_rise_c) begin
                    state_nxt = ST_ISSUE;
                end else if (timeout_c) begin
                    state_nxt = ST_IDLE;
                end else if (user_rise_c && digit_ok_c) begin
                    usr_nxt  = CODE_W'({usr_r, digit_q});
                    dcnt_nxt = dcnt + CNT_W'(1);
                    if (dcnt + CNT_W'(1) == CNT_W'(DIGITS)) state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (usr_r == otp_r) begin
                    unlock_nxt = 1'b1;
                    wrng_nxt   = '0;
                    state_nxt  = ST_UNLOCKED;
                end else begin
                    wrng_nxt = wrng_r + ATT_W'(1);
                    if (wrng_r + ATT_W'(1) == ATT_W'(MAX_ATTEMPTS)) begin
                        locked_nxt = 1'b1;
                        lcnt_nxt   = '0;
                        state_nxt  = ST_LOCKOUT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (otp_rise_c) begin
                    unlock_nxt = 1'b0;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_LOCKOUT: begin
                lcnt_nxt = lcnt + LOCK_W'(1);
                if (lcnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                    locked_nxt = 1'b0;
                    wrng_nxt   = '0;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.otp_digits  = otp_r;
    assign bus.user_digits = usr_r;
    assign bus.unlock      = unlock_r;
    assign bus.locked      = locked_r;
    assign bus.wrng_atmpt  = wrng_r;

endmodule

// File: tb/tb_otp_auth_engine.sv
// Directed bench for otp_auth_engine; the timeout section follows OTP_AUTH_TIMEOUT_EN.
module tb_otp_auth_engine;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    otp_auth_engine_if #(.DIGITS(4), .MAX_ATTEMPTS(3)) bus ();

    otp_auth_engine #(
        .DIGITS        (4),
        .LFSR_W        (16),
        .SEED          (32'h0000_ACE1),
        .MAX_ATTEMPTS  (3),
        .EXPIRE_CYCLES (1000),
        .LOCK_CYCLES   (200)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] mdl;
    logic [15:0] exp_otp;

    // Reference PRNG, stepped independently of the design
    always @(posedge clk or posedge reset) begin
        if (reset) mdl <= SEED;
        else       mdl <= mdl[0] ? ((mdl >> 1) ^ TAPS) : (mdl >> 1);
    end

    function automatic logic [15:0] to_bcd(input logic [15:0] v);
        logic [15:0] r;
        logic [3:0]  n;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            n = v[4*k +: 4];
            r[4*k +: 4] = (n > 4'd9) ? n - 4'd10 : n;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " otp_digits"},  32'(bus.otp_digits),  32'h0);
        chk({tag, " user_digits"}, 32'(bus.user_digits), 32'h0);
        chk({tag, " unlock"},      32'(bus.unlock),      32'h0);
        chk({tag, " locked"},      32'(bus.locked),      32'h0);
        chk({tag, " expired"},     32'(bus.expired),     32'h0);
        chk({tag, " wrng"},        32'(bus.wrng_atmpt),  32'h0);
    endtask

    // OTP press; returns on the cycle otp_digits becomes valid and ENTRY begins
    task automatic otp_press();
        bus.otp_latch = 1'b1;
        tick();
        bus.otp_latch = 1'b0;
        tick();
        exp_otp = to_bcd(mdl);
        tick();
    endtask

    // Returns in the cycle after the rise pulse (user_digits updated)
    task automatic user_press(input logic [3:0] d);
        bus.user_digit = d;
        bus.user_latch = 1'b1;
        tick();
        bus.user_latch = 1'b0;
        tick();
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) user_press(code[4*i +: 4]);
    endtask

    // Reset, then press otp immediately on release: ISSUE sees the 2nd LFSR state 16'h7138
    task automatic reset_and_issue(input string tag);
        bus.otp_latch  = 1'b0;
        bus.user_latch = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        chk_reset_vals(tag);
        reset = 1'b0;
        bus.otp_latch = 1'b1;
        tick();
        bus.otp_latch = 1'b0;
        tick();
        tick();
        chk({tag, " first otp"}, 32'(bus.otp_digits), 32'h7138);
        chk({tag, " user cleared"}, 32'(bus.user_digits), 32'h0);
    endtask

    typedef struct {
        logic        use_otp;
        logic [15:0] code;
        logic        exp_unlock;
        logic [1:0]  exp_wrng;
        logic        exp_locked;
    } sess_t;

    sess_t tbl[5];

    initial begin
        tbl[0] = '{1'b0, 16'h9999, 1'b0, 2'd1, 1'b0};
        tbl[1] = '{1'b1, 16'h0000, 1'b1, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 16'h9999, 1'b0, 2'd1, 1'b0};
        tbl[3] = '{1'b0, 16'h1234, 1'b0, 2'd2, 1'b0};
        tbl[4] = '{1'b0, 16'h9999, 1'b0, 2'd3, 1'b1};

        bus.user_digit = 4'd0;
        bus.otp_latch  = 1'b0;
        bus.user_latch = 1'b0;

        // Reset values, first OTP and a correct entry
        reset_and_issue("rst1");
        enter_code(16'h7138);
        chk("first check pending", 32'(bus.unlock), 32'h0);
        tick();
        chk("first unlock", 32'(bus.unlock), 32'h1);
        chk("first wrng", 32'(bus.wrng_atmpt), 32'h0);
        chk("first user_digits", 32'(bus.user_digits), 32'h7138);

        // Session table: good/bad codes drive the attempt counter to lockout
        for (int s = 0; s < 5; s++) begin
            otp_press();
            chk($sformatf("s%0d otp", s), 32'(bus.otp_digits), 32'(exp_otp));
            chk($sformatf("s%0d unlock cleared", s), 32'(bus.unlock), 32'h0);
            enter_code(tbl[s].use_otp ? exp_otp : tbl[s].code);
            tick();
            chk($sformatf("s%0d unlock", s), 32'(bus.unlock), 32'(tbl[s].exp_unlock));
            chk($sformatf("s%0d wrng", s), 32'(bus.wrng_atmpt), 32'(tbl[s].exp_wrng));
            chk($sformatf("s%0d locked", s), 32'(bus.locked), 32'(tbl[s].exp_locked));
        end

        // Lockout: presses ignored, locked high for exactly 200 cycles
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (k == 2) begin
                bus.user_digit = 4'd5;
                bus.otp_latch  = 1'b1;
                bus.user_latch = 1'b1;
            end
            if (k == 4) begin
                bus.otp_latch  = 1'b0;
                bus.user_latch = 1'b0;
            end
            if (k == 10) begin
                chk("lock otp held", 32'(bus.otp_digits), 32'(exp_otp));
                chk("lock user held", 32'(bus.user_digits), 32'h9999);
                chk("lock wrng", 32'(bus.wrng_atmpt), 32'h3);
            end
            if (k == 199) chk("lock last cycle", 32'(bus.locked), 32'h1);
            if (k == 200) begin
                chk("lock released", 32'(bus.locked), 32'h0);
                chk("lock wrng cleared", 32'(bus.wrng_atmpt), 32'h0);
            end
        end

        // Invalid digit ignored; simultaneous otp+user rise restarts the session
        otp_press();
        chk("inv otp", 32'(bus.otp_digits), 32'(exp_otp));
        user_press(exp_otp[15:12]);
        chk("inv d0", 32'(bus.user_digits), 32'({12'h0, exp_otp[15:12]}));
        user_press(4'hC);
        chk("inv ignored", 32'(bus.user_digits), 32'({12'h0, exp_otp[15:12]}));
        user_press(exp_otp[11:8]);
        chk("inv d1", 32'(bus.user_digits), 32'({8'h0, exp_otp[15:8]}));
        bus.user_digit = 4'd5;
        bus.otp_latch  = 1'b1;
        bus.user_latch = 1'b1;
        tick();
        bus.otp_latch  = 1'b0;
        bus.user_latch = 1'b0;
        tick();
        exp_otp = to_bcd(mdl);
        tick();
        chk("sim new otp", 32'(bus.otp_digits), 32'(exp_otp));
        chk("sim user cleared", 32'(bus.user_digits), 32'h0);
        user_press(exp_otp[15:12]);
        user_press(exp_otp[11:8]);
        user_press(4'hF);
        user_press(exp_otp[7:4]);
        chk("inv no early check", 32'(bus.unlock), 32'h0);
        user_press(exp_otp[3:0]);
        tick();
        chk("inv unlock", 32'(bus.unlock), 32'h1);
        chk("inv wrng", 32'(bus.wrng_atmpt), 32'h0);

        // Entry window: two digits then idle
        otp_press();
        user_press(exp_otp[15:12]);
        user_press(exp_otp[11:8]);
`ifdef OTP_AUTH_TIMEOUT_EN
        for (int t = 5; t <= 1000; t++) begin
            tick();
            if (t == 999)  chk("exp not yet", 32'(bus.expired), 32'h0);
            if (t == 1000) chk("exp set", 32'(bus.expired), 32'h1);
        end
        repeat (5) tick();
        chk("exp held", 32'(bus.expired), 32'h1);
        otp_press();
        chk("exp cleared", 32'(bus.expired), 32'h0);
        chk("exp new otp", 32'(bus.otp_digits), 32'(exp_otp));
`else
        repeat (5000) tick();
        chk("noexp flag", 32'(bus.expired), 32'h0);
        chk("noexp user held", 32'(bus.user_digits), 32'({8'h0, exp_otp[15:8]}));
        user_press(exp_otp[7:4]);
        user_press(exp_otp[3:0]);
        tick();
        chk("noexp unlock", 32'(bus.unlock), 32'h1);
        otp_press();
`endif

        // Asynchronous reset in ENTRY after 3 digits, then restart from SEED
        user_press(exp_otp[15:12]);
        user_press(exp_otp[11:8]);
        user_press(exp_otp[7:4]);
        chk("pre-rst user", 32'(bus.user_digits), 32'({4'h0, exp_otp[15:4]}));
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        reset_and_issue("rst2");
        enter_code(16'h7138);
        tick();
        chk("rst2 unlock", 32'(bus.unlock), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
